// File: rtl/struct_field_unpacker_if.sv
// Handshake bundle between a packed-word producer, the field unpacker and the
// downstream field consumer.
interface struct_field_unpacker_if #(
  parameter int FIELD_WIDTH = 10,
  parameter int NUM_FIELDS  = 2
);
  localparam int IW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

  logic                              i_in_valid;
  logic                              o_in_ready;
  logic [NUM_FIELDS*FIELD_WIDTH-1:0] i_in_data;
  logic                              o_out_valid;
  logic                              i_out_ready;
  logic [FIELD_WIDTH-1:0]            o_out_data;
  logic [IW-1:0]                     o_out_index;
  logic                              o_out_last;
  logic                              o_drop;

  modport slave (
    input  i_in_valid, i_in_data, i_out_ready,
    output o_in_ready, o_out_valid, o_out_data, o_out_index, o_out_last, o_drop
  );

  modport master (
    output i_in_valid, i_in_data, i_out_ready,
    input  o_in_ready, o_out_valid, o_out_data, o_out_index, o_out_last, o_drop
  );
endinterface

// File: rtl/struct_field_unpacker.sv
// Streams the fields of a packed word out one per beat, field 0 (MSBs) first,
// optionally dropping zero-valued fields.
module struct_field_unpacker #(
  parameter int FIELD_WIDTH = 10,
  parameter int NUM_FIELDS  = 2,
  parameter bit SKIP_ZERO   = 1'b0
) (
  input logic i_clk,
  input logic i_rst,
  struct_field_unpacker_if.slave bus
);
  localparam int WW = NUM_FIELDS * FIELD_WIDTH;
  localparam int IW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                 state_q, state_d;
  logic [WW-1:0]          word_q, word_d;
  logic [FIELD_WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   last_q, last_d;
  logic                   drop_q, drop_d;

  logic inReady;
  logic accept;
  logic beatDone;
  int   firstNew, secondNew, nextCur, nextSat, afterNext;

  function automatic logic [FIELD_WIDTH-1:0] fieldOf(input logic [WW-1:0] w, input int k);
    return w[(NUM_FIELDS-1-k)*FIELD_WIDTH +: FIELD_WIDTH];
  endfunction

  // Lowest emitted field index at or above 'from'; NUM_FIELDS means none left.
  function automatic int findFrom(input logic [WW-1:0] w, input int from);
    int res;
    res = NUM_FIELDS;
    for (int k = NUM_FIELDS-1; k >= 0; k--) begin
      if (k >= from && (!SKIP_ZERO || fieldOf(w, k) != '0)) res = k;
    end
    return res;
  endfunction

  always_comb begin
    inReady   = (state_q == IDLE) || (last_q && bus.i_out_ready);
    accept    = bus.i_in_valid && inReady;
    beatDone  = (state_q == EMIT) && bus.i_out_ready;
    firstNew  = findFrom(bus.i_in_data, 0);
    secondNew = findFrom(bus.i_in_data, firstNew + 1);
    nextCur   = findFrom(word_q, int'(idx_q) + 1);
    nextSat   = (nextCur > NUM_FIELDS-1) ? NUM_FIELDS-1 : nextCur;
    afterNext = findFrom(word_q, nextSat + 1);

    state_d = state_q;
    word_d  = word_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    drop_d  = 1'b0;

    // A new word takes priority; it can only arrive alongside the final beat.
    if (accept) begin
      word_d = bus.i_in_data;
      if (firstNew >= NUM_FIELDS) begin
        state_d = IDLE;
        drop_d  = 1'b1;
      end else begin
        state_d = EMIT;
        data_d  = fieldOf(bus.i_in_data, firstNew);
        idx_d   = IW'(firstNew);
        last_d  = (secondNew >= NUM_FIELDS);
      end
    end else if (beatDone) begin
      if (last_q) begin
        state_d = IDLE;
      end else begin
        data_d = fieldOf(word_q, nextSat);
        idx_d  = IW'(nextSat);
        last_d = (afterNext >= NUM_FIELDS);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.o_in_ready  = inReady;
  assign bus.o_out_valid = (state_q == EMIT);
  assign bus.o_out_data  = data_q;
  assign bus.o_out_index = idx_q;
  assign bus.o_out_last  = last_q;
  assign bus.o_drop      = drop_q;
endmodule

// File: tb/tb_struct_field_unpacker.sv
// Bench for struct_field_unpacker: three configurations checked against a
// beat-list model every cycle, plus literal expectations for each scenario.
module tb_struct_field_unpacker;
  logic clock;
  logic reset;

  int checks;
  int errors;

  typedef struct {
    int data;
    int idx;
    bit last;
  } beat_t;

  beat_t expA[$];
  beat_t expS[$];
  beat_t expW[$];
  bit    expectDrop [3];

  struct_field_unpacker_if #(.FIELD_WIDTH(10), .NUM_FIELDS(2)) ifA ();
  struct_field_unpacker_if #(.FIELD_WIDTH(10), .NUM_FIELDS(2)) ifS ();
  struct_field_unpacker_if #(.FIELD_WIDTH(8),  .NUM_FIELDS(4)) ifW ();

  struct_field_unpacker #(.FIELD_WIDTH(10), .NUM_FIELDS(2), .SKIP_ZERO(1'b0)) dutA (
    .i_clk(clock), .i_rst(reset), .bus(ifA)
  );
  struct_field_unpacker #(.FIELD_WIDTH(10), .NUM_FIELDS(2), .SKIP_ZERO(1'b1)) dutS (
    .i_clk(clock), .i_rst(reset), .bus(ifS)
  );
  struct_field_unpacker #(.FIELD_WIDTH(8), .NUM_FIELDS(4), .SKIP_ZERO(1'b0)) dutW (
    .i_clk(clock), .i_rst(reset), .bus(ifW)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clock);
    #1;
  endtask

  function automatic beat_t headOf(input int u);
    beat_t b;
    b = '{data: 0, idx: 0, last: 1'b0};
    case (u)
      0: if (expA.size() != 0) b = expA[0];
      1: if (expS.size() != 0) b = expS[0];
      default: if (expW.size() != 0) b = expW[0];
    endcase
    return b;
  endfunction

  function automatic int depthOf(input int u);
    case (u)
      0: return expA.size();
      1: return expS.size();
      default: return expW.size();
    endcase
  endfunction

  task automatic popExp(input int u);
    case (u)
      0: void'(expA.pop_front());
      1: void'(expS.pop_front());
      default: void'(expW.pop_front());
    endcase
  endtask

  task automatic pushExp(input int u, input beat_t b);
    case (u)
      0: expA.push_back(b);
      1: expS.push_back(b);
      default: expW.push_back(b);
    endcase
  endtask

  // Model: a word expands into the list of fields that will appear, MSB field first.
  task automatic observe(input int u, input bit ov, input bit ordy, input int data,
                         input int idx, input bit last, input bit ivld, input bit irdy,
                         input logic [31:0] idata, input bit drop);
    int    fw, nf, n, emitted, f;
    bit    skip;
    beat_t h, b;
    string tag;
    fw   = (u == 2) ? 8 : 10;
    nf   = (u == 2) ? 4 : 2;
    skip = (u == 1);
    tag  = (u == 0) ? "A" : ((u == 1) ? "S" : "W");

    checkOutput({tag, " drop"}, longint'(drop), longint'(expectDrop[u]));
    expectDrop[u] = 1'b0;

    checkOutput({tag, " out_valid"}, longint'(ov), longint'(depthOf(u) != 0));
    if (ov && depthOf(u) != 0) begin
      h = headOf(u);
      checkOutput({tag, " out_data"}, longint'(data), longint'(h.data));
      checkOutput({tag, " out_index"}, longint'(idx), longint'(h.idx));
      checkOutput({tag, " out_last"}, longint'(last), longint'(h.last));
      if (ordy) popExp(u);
    end
    checkOutput({tag, " in_ready"}, longint'(irdy), longint'(depthOf(u) == 0));

    if (ivld && irdy) begin
      n = 0;
      for (int k = 0; k < nf; k++) begin
        f = int'((idata >> ((nf-1-k)*fw)) & ((32'd1 << fw) - 32'd1));
        if (!skip || f != 0) n++;
      end
      if (n == 0) expectDrop[u] = 1'b1;
      emitted = 0;
      for (int k = 0; k < nf; k++) begin
        f = int'((idata >> ((nf-1-k)*fw)) & ((32'd1 << fw) - 32'd1));
        if (!skip || f != 0) begin
          emitted++;
          b = '{data: f, idx: k, last: (emitted == n)};
          pushExp(u, b);
        end
      end
    end
  endtask

  // Every mid-cycle, compare all three units against the model.
  always @(negedge clock) begin
    if (reset) begin
      expA.delete();
      expS.delete();
      expW.delete();
      for (int u = 0; u < 3; u++) expectDrop[u] = 1'b0;
    end else begin
      observe(0, ifA.o_out_valid, ifA.i_out_ready, int'(ifA.o_out_data), int'(ifA.o_out_index),
              ifA.o_out_last, ifA.i_in_valid, ifA.o_in_ready, 32'(ifA.i_in_data), ifA.o_drop);
      observe(1, ifS.o_out_valid, ifS.i_out_ready, int'(ifS.o_out_data), int'(ifS.o_out_index),
              ifS.o_out_last, ifS.i_in_valid, ifS.o_in_ready, 32'(ifS.i_in_data), ifS.o_drop);
      observe(2, ifW.o_out_valid, ifW.i_out_ready, int'(ifW.o_out_data), int'(ifW.o_out_index),
              ifW.o_out_last, ifW.i_in_valid, ifW.o_in_ready, 32'(ifW.i_in_data), ifW.o_drop);
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    ifA.i_in_valid = 1'b0; ifA.i_in_data = '0; ifA.i_out_ready = 1'b1;
    ifS.i_in_valid = 1'b0; ifS.i_in_data = '0; ifS.i_out_ready = 1'b1;
    ifW.i_in_valid = 1'b0; ifW.i_in_data = '0; ifW.i_out_ready = 1'b1;
    #2;
    checkOutput("reset in_ready", longint'(ifA.o_in_ready), 1);
    checkOutput("reset out_valid", longint'(ifA.o_out_valid), 0);
    checkOutput("reset out_data", longint'(ifA.o_out_data), 0);
    checkOutput("reset out_index", longint'(ifA.o_out_index), 0);
    checkOutput("reset out_last", longint'(ifA.o_out_last), 0);
    checkOutput("reset drop", longint'(ifA.o_drop), 0);
    applyStimulus(2);
    reset = 1'b0;
    applyStimulus(1);

    // Plain two-field word.
    ifA.i_in_valid = 1'b1; ifA.i_in_data = 20'hFA00A;
    applyStimulus(1);
    ifA.i_in_valid = 1'b0;
    checkOutput("basic beat0 data", longint'(ifA.o_out_data), 1000);
    checkOutput("basic beat0 idx", longint'(ifA.o_out_index), 0);
    checkOutput("basic beat0 last", longint'(ifA.o_out_last), 0);
    applyStimulus(1);
    checkOutput("basic beat1 data", longint'(ifA.o_out_data), 10);
    checkOutput("basic beat1 idx", longint'(ifA.o_out_index), 1);
    checkOutput("basic beat1 last", longint'(ifA.o_out_last), 1);
    applyStimulus(1);
    checkOutput("basic done valid", longint'(ifA.o_out_valid), 0);

    // Backpressure holds the first beat for three cycles.
    ifA.i_out_ready = 1'b0;
    ifA.i_in_valid = 1'b1; ifA.i_in_data = 20'hFA00A;
    applyStimulus(1);
    ifA.i_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp held data", longint'(ifA.o_out_data), 1000);
      checkOutput("bp held idx", longint'(ifA.o_out_index), 0);
      checkOutput("bp in_ready", longint'(ifA.o_in_ready), 0);
      if (i == 2) ifA.i_out_ready = 1'b1;
      applyStimulus(1);
    end
    checkOutput("bp beat1 data", longint'(ifA.o_out_data), 10);
    checkOutput("bp beat1 last", longint'(ifA.o_out_last), 1);
    applyStimulus(1);
    checkOutput("bp done valid", longint'(ifA.o_out_valid), 0);

    // Back-to-back words, second accepted alongside the last beat of the first.
    ifA.i_in_valid = 1'b1; ifA.i_in_data = 20'hFA00A;
    applyStimulus(1);
    ifA.i_in_data = 20'h01405;
    checkOutput("b2b beat0 data", longint'(ifA.o_out_data), 1000);
    applyStimulus(1);
    checkOutput("b2b beat1 data", longint'(ifA.o_out_data), 10);
    checkOutput("b2b in_ready on last", longint'(ifA.o_in_ready), 1);
    applyStimulus(1);
    ifA.i_in_valid = 1'b0;
    checkOutput("b2b beat2 data", longint'(ifA.o_out_data), 5);
    checkOutput("b2b beat2 idx", longint'(ifA.o_out_index), 0);
    checkOutput("b2b beat2 valid", longint'(ifA.o_out_valid), 1);
    applyStimulus(1);
    checkOutput("b2b beat3 data", longint'(ifA.o_out_data), 5);
    checkOutput("b2b beat3 last", longint'(ifA.o_out_last), 1);
    applyStimulus(1);
    checkOutput("b2b done valid", longint'(ifA.o_out_valid), 0);

    // Zero-skipping unit.
    ifS.i_in_valid = 1'b1; ifS.i_in_data = 20'h02800;
    applyStimulus(1);
    ifS.i_in_valid = 1'b0;
    checkOutput("skip a-only data", longint'(ifS.o_out_data), 10);
    checkOutput("skip a-only idx", longint'(ifS.o_out_index), 0);
    checkOutput("skip a-only last", longint'(ifS.o_out_last), 1);
    applyStimulus(1);
    checkOutput("skip a-only done", longint'(ifS.o_out_valid), 0);
    ifS.i_in_valid = 1'b1; ifS.i_in_data = 20'h00007;
    applyStimulus(1);
    ifS.i_in_valid = 1'b0;
    checkOutput("skip b-only data", longint'(ifS.o_out_data), 7);
    checkOutput("skip b-only idx", longint'(ifS.o_out_index), 1);
    checkOutput("skip b-only last", longint'(ifS.o_out_last), 1);
    applyStimulus(1);
    ifS.i_in_valid = 1'b1; ifS.i_in_data = 20'h00000;
    applyStimulus(1);
    ifS.i_in_valid = 1'b0;
    checkOutput("skip zero drop", longint'(ifS.o_drop), 1);
    checkOutput("skip zero valid", longint'(ifS.o_out_valid), 0);
    checkOutput("skip zero in_ready", longint'(ifS.o_in_ready), 1);
    applyStimulus(1);
    checkOutput("skip zero drop gone", longint'(ifS.o_drop), 0);

    // Asynchronous reset while the idx1 beat is pending.
    ifA.i_in_valid = 1'b1; ifA.i_in_data = 20'hFA00A;
    applyStimulus(1);
    ifA.i_in_valid = 1'b0;
    applyStimulus(1);
    checkOutput("rstmid pre idx", longint'(ifA.o_out_index), 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rstmid valid", longint'(ifA.o_out_valid), 0);
    checkOutput("rstmid in_ready", longint'(ifA.o_in_ready), 1);
    checkOutput("rstmid data", longint'(ifA.o_out_data), 0);
    checkOutput("rstmid idx", longint'(ifA.o_out_index), 0);
    checkOutput("rstmid last", longint'(ifA.o_out_last), 0);
    @(negedge clock);
    #2;
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("rstmid no resume 1", longint'(ifA.o_out_valid), 0);
    applyStimulus(1);
    checkOutput("rstmid no resume 2", longint'(ifA.o_out_valid), 0);
    ifA.i_in_valid = 1'b1; ifA.i_in_data = 20'h01405;
    applyStimulus(1);
    ifA.i_in_valid = 1'b0;
    checkOutput("rstmid new beat0", longint'(ifA.o_out_data), 5);
    applyStimulus(1);
    checkOutput("rstmid new beat1 idx", longint'(ifA.o_out_index), 1);
    checkOutput("rstmid new beat1 last", longint'(ifA.o_out_last), 1);
    applyStimulus(1);

    // Four 8-bit fields.
    ifW.i_in_valid = 1'b1; ifW.i_in_data = 32'h11223344;
    applyStimulus(1);
    ifW.i_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput("wide data", longint'(ifW.o_out_data), longint'(8'h11 * (k + 1)));
      checkOutput("wide idx", longint'(ifW.o_out_index), longint'(k));
      checkOutput("wide last", longint'(ifW.o_out_last), longint'(k == 3));
      applyStimulus(1);
    end
    checkOutput("wide done valid", longint'(ifW.o_out_valid), 0);

    applyStimulus(3);
    checkOutput("model A drained", longint'(expA.size()), 0);
    checkOutput("model S drained", longint'(expS.size()), 0);
    checkOutput("model W drained", longint'(expW.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/struct_field_unpacker.md
Name: struct_field_unpacker

Overview:
- Streaming unpacker: the receive-side counterpart of packed-struct construction.
- Accepts a packed word of NUM_FIELDS fields of FIELD_WIDTH bits each, and emits the fields one per beat on a valid/ready stream.
- Field 0 sits in the MSBs, matching declaration order in packed structs.
- Optional default-skip mode drops zero-valued fields, mirroring "default: 0" construction.

Parameters:
- FIELD_WIDTH, 10: bits per field.
- NUM_FIELDS, 2: fields per packed word; must be ≥ 2.
- SKIP_ZERO, 0: 1 = fields equal to zero are not emitted.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset; asynchronous, active-high.
- i_in_valid  input  1  packed word valid.
- o_in_ready  output  1  unpacker can accept a word.
- i_in_data  input  NUM_FIELDS*FIELD_WIDTH  packed word; field k occupies bits [(NUM_FIELDS-k)*FIELD_WIDTH-1 -: FIELD_WIDTH].
- o_out_valid  output  1  field beat valid.
- i_out_ready  input  1  downstream accepts beat.
- o_out_data  output  FIELD_WIDTH  field value.
- o_out_index  output  max(1,$clog2(NUM_FIELDS))  field number k.
- o_out_last  output  1  final emitted beat of the current word.
- o_drop  output  1  one-cycle pulse: word accepted but produced no beats (SKIP_ZERO=1, all fields zero).

Behaviour:
- Reset values: o_in_ready=1, o_out_valid=0, o_out_data=0, o_out_index=0, o_out_last=0, o_drop=0. Holding register cleared; state IDLE.
- Reset asserted mid-word: the word is discarded and never resumes.
- States:
  - IDLE: no word held. o_in_ready=1, o_out_valid=0.
  - EMIT: word held. o_out_valid=1. The current field is output registered.
- Accept: in_valid & in_ready at edge N latches the word.
  - The first emitted field is presented from cycle N+1 (latency 1).
  - State goes to EMIT unless all fields are skipped. In that case state stays IDLE and o_drop=1 during cycle N+1.
- o_in_ready = IDLE, OR (EMIT & o_out_last & i_out_ready). This gives back-to-back words with no bubble.
- Beat order: ascending index.
- SKIP_ZERO=1: the next index is the lowest index greater than the current one whose field is non-zero.
- o_out_last=1 when no later field would be emitted.
- Beat completes on o_out_valid & i_out_ready:
  - If not last: advance to the next emitted field.
  - If last and a new word is accepted in the same cycle: load the new word's first field (EMIT persists, or IDLE+drop if the new word is all-zero).
  - If last and no new word: go to IDLE.
- Backpressure: while o_out_valid=1 & i_out_ready=0, o_out_data, o_out_index and o_out_last are held stable.
- i_in_data is sampled only on accept; changes at other times have no effect.
- In IDLE, o_out_data/o_out_index/o_out_last hold their previous values and are don't-care to consumers.
- No arithmetic beyond the index increment/search. The index saturates logic at NUM_FIELDS-1; it never wraps within a word.

Test Plan:
- Defaults. Word a=1000, bb=10 (i_in_data=0xFA00A), out_ready=1.
  - Cycle N+1: data=1000, idx=0, last=0.
  - N+2: data=10, idx=1, last=1.
  - N+3: out_valid=0.
- Backpressure. Same word with out_ready=0 for 3 cycles after accept.
  - data=1000/idx=0 held 3 cycles; o_in_ready=0.
  - Then completes as above.
- Back-to-back. Word 0xFA00A then word a=5, bb=5 (0x01405) presented continuously, out_ready=1.
  - Beats 1000, 10(last), 5, 5(last) on 4 consecutive cycles.
  - Second word accepted in the same cycle as the 10 beat.
- SKIP_ZERO=1.
  - Word a=10, bb=0 (0x02800) → single beat data=10, idx=0, last=1.
  - Word a=0, bb=7 → single beat data=7, idx=1, last=1.
  - Word 0 → o_drop=1 for one cycle, no out_valid, o_in_ready stays 1.
- Reset mid-word. Assert i_rst asynchronously (between edges) after beat idx0 of 0xFA00A.
  - Outputs go to reset values immediately.
  - After release, no idx1 beat appears.
  - A new word unpacks normally.
- NUM_FIELDS=4, FIELD_WIDTH=8. Word 0x11223344 → beats 0x11, 0x22, 0x33, 0x44 with idx 0..3; last only on 0x44.
